// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES stimulus sequencer: FSM states,
// pipeline latency, MISR feedback polynomial and default widths.
package aes_seq_pkg;

  localparam int AES_LATENCY = 21;
  localparam int CNT_W_DEF   = 32;
  localparam int DATA_W_DEF  = 128;

  // x^128 + x^29 + x^27 + x^2 + 1, the x^128 term is implicit in the shift-out
  localparam logic [127:0] MISR_POLY = 128'h2800_0005;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    WARM,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/aes_valid_pipe.sv
// Single-bit shift register that tracks which AES pipeline slots carry a
// counted test; the last stage lines up with the ciphertext on the AES output.
module aes_valid_pipe #(
  parameter int DEPTH = 21
) (
  input  logic clk,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (clear) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], din};
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/aes_stim_sequencer.sv
// Sequences LFSR seeding, AES clock enable and ciphertext tagging for a run of N encryptions.
// Optional MISR signature over tagged ciphertexts is enabled with `define AES_SEQ_SIGNATURE_EN.
module aes_stim_sequencer
  import aes_seq_pkg::*;
#(
  parameter int LATENCY = AES_LATENCY,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tests,
  input  logic [DATA_W-1:0] ct_in,
  output logic              lfsr_load_seed,
  output logic              lfsr_enable,
  output logic              aes_enable,
  output logic              ct_valid,
  output logic [CNT_W-1:0]  ct_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] signature
);

  seq_state_t       state;
  logic [CNT_W-1:0] phase_cnt;
  logic             accept;

  assign accept = (state == IDLE) && start && (num_tests != '0);

  aes_valid_pipe #(
    .DEPTH (LATENCY)
  ) u_valid_pipe (
    .clk   (clk),
    .clear (!rst_n),
    .din   (state == RUN),
    .dout  (ct_valid)
  );

  // phase_cnt holds N through SEED/WARM, then counts RUN and DRAIN down to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      ct_count       <= '0;
      lfsr_load_seed <= 1'b0;
      lfsr_enable    <= 1'b0;
      aes_enable     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (ct_valid) begin
        ct_count <= ct_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SEED;
            phase_cnt      <= num_tests;
            ct_count       <= '0;
            lfsr_load_seed <= 1'b1;
            lfsr_enable    <= 1'b1;
            busy           <= 1'b1;
          end
        end
        SEED: begin
          state          <= WARM;
          lfsr_load_seed <= 1'b0;
        end
        WARM: begin
          state      <= RUN;
          aes_enable <= 1'b1;
        end
        RUN: begin
          if (phase_cnt == CNT_W'(1)) begin
            state     <= DRAIN;
            phase_cnt <= CNT_W'(LATENCY);
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
          if (phase_cnt == CNT_W'(1)) begin
            state       <= DONE;
            lfsr_enable <= 1'b0;
            aes_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_SEQ_SIGNATURE_EN
  localparam logic [DATA_W-1:0] POLY = DATA_W'(MISR_POLY);

  logic [DATA_W-1:0] sig_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      sig_reg <= '0;
    end else if (ct_valid) begin
      sig_reg <= ({sig_reg[DATA_W-2:0], 1'b0} ^ (sig_reg[DATA_W-1] ? POLY : '0)) ^ ct_in;
    end
  end

  assign signature = sig_reg;
`else
  logic unused_ct_in;

  assign unused_ct_in = ^ct_in;
  assign signature    = '0;
`endif

endmodule

// File: tb/tb_aes_stim_sequencer.sv
// Self-checking bench for aes_stim_sequencer: a run-offset reference model is compared
// against every output each cycle, plus directed literal checks on key timing points.
module tb_aes_stim_sequencer;

  localparam int LAT = 21;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  num_tests = '0;
  logic [127:0] ct_in = '0;
  logic         lfsr_load_seed, lfsr_enable, aes_enable, ct_valid, busy, done;
  logic [31:0]  ct_count;
  logic [127:0] signature;

  int n_checks = 0;
  int n_fail   = 0;

  aes_stim_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_tests      (num_tests),
    .ct_in          (ct_in),
    .lfsr_load_seed (lfsr_load_seed),
    .lfsr_enable    (lfsr_enable),
    .aes_enable     (aes_enable),
    .ct_valid       (ct_valid),
    .ct_count       (ct_count),
    .busy           (busy),
    .done           (done),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  // Fresh random ciphertext word every cycle, changed well away from the edge
  always @(posedge clk) begin
    #1;
    ct_in = {$urandom, $urandom, $urandom, $urandom};
  end

  function automatic logic [127:0] misr_step(input logic [127:0] s, input logic [127:0] d);
    logic [127:0] r;
    r = s << 1;
    if (s[127]) r = r ^ 128'h2800_0005;
    return r ^ d;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is described by its offset k from the accept edge.
  // k=0 seed, k=1 warm, k=2..n+1 run, k=n+2..n+22 drain, k=n+23 done.
  logic         m_active = 1'b0;
  longint       m_k = 0;
  longint       m_n = 0;
  logic [31:0]  m_count = '0;
  logic [127:0] m_sig = '0;

  always @(posedge clk) begin : ref_model
    logic         act;
    longint       k, n;
    logic [31:0]  cnt;
    logic [127:0] sig;
    act = m_active; k = m_k; n = m_n; cnt = m_count; sig = m_sig;
    if (!rst_n) begin
      act = 1'b0; k = 0; n = 0; cnt = '0; sig = '0;
    end else begin
      if (act && k >= LAT + 2 && k <= n + LAT + 1) begin
        cnt = cnt + 1;
        sig = misr_step(sig, ct_in);
      end
      if (act) begin
        if (k < n + LAT + 2) k = k + 1;
        else if (!start) act = 1'b0;
      end else if (start && num_tests != 0) begin
        act = 1'b1; k = 0; n = longint'(num_tests); cnt = '0; sig = '0;
      end
    end
    m_active <= act; m_k <= k; m_n <= n; m_count <= cnt; m_sig <= sig;
  end

  logic started = 1'b0;
  always @(posedge clk) started <= 1'b1;

  // Per-run observation counters for the directed checks
  int mon_cyc = 0, mon_seed = 0, mon_aes = 0, mon_valid = 0;
  int mon_first_aes = -1, mon_first_valid = -1, mon_last_valid = -1;

  task automatic clearMon();
    mon_seed = 0; mon_aes = 0; mon_valid = 0;
    mon_first_aes = -1; mon_first_valid = -1; mon_last_valid = -1;
  endtask

  always @(negedge clk) begin : compare
    logic         e_seed, e_lfsr, e_aes, e_valid, e_done;
    logic [127:0] e_sig;
    if (started) begin
      e_seed  = m_active && m_k == 0;
      e_lfsr  = m_active && m_k <= m_n + LAT + 1;
      e_aes   = m_active && m_k >= 2 && m_k <= m_n + LAT + 1;
      e_valid = m_active && m_k >= LAT + 2 && m_k <= m_n + LAT + 1;
      e_done  = m_active && m_k == m_n + LAT + 2;
`ifdef AES_SEQ_SIGNATURE_EN
      e_sig = m_sig;
`else
      e_sig = '0;
`endif
      checkOutput("lfsr_load_seed", 128'(lfsr_load_seed), 128'(e_seed));
      checkOutput("lfsr_enable", 128'(lfsr_enable), 128'(e_lfsr));
      checkOutput("aes_enable", 128'(aes_enable), 128'(e_aes));
      checkOutput("ct_valid", 128'(ct_valid), 128'(e_valid));
      checkOutput("busy", 128'(busy), 128'(e_lfsr));
      checkOutput("done", 128'(done), 128'(e_done));
      checkOutput("ct_count", 128'(ct_count), 128'(m_count));
      checkOutput("signature", signature, e_sig);

      mon_cyc++;
      if (lfsr_load_seed) mon_seed++;
      if (aes_enable) begin
        mon_aes++;
        if (mon_first_aes < 0) mon_first_aes = mon_cyc;
      end
      if (ct_valid) begin
        mon_valid++;
        if (mon_first_valid < 0) mon_first_valid = mon_cyc;
        mon_last_valid = mon_cyc;
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic [31:0] n);
    @(posedge clk);
    #1;
    rst_n = r;
    start = s;
    num_tests = n;
  endtask

  task automatic waitDone(input int budget);
    int i;
    for (i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_done: done still 0 after %0d cycles, expected 1", budget);
    end
  endtask

  initial begin
    logic [31:0] n;
    int dcnt;

    // Model pins: shift without feedback, feedback on MSB out, data xor
    checkOutput("misr_shift", misr_step(128'h1, '0), 128'h2);
    checkOutput("misr_poly", misr_step({1'b1, 127'h0}, '0), 128'h2800_0005);
    checkOutput("misr_data", misr_step(128'h3, 128'h5), 128'h3);

    // 1: reset held three cycles, then idle with start low
    repeat (3) applyStimulus(1'b0, 1'b0, '0);
    repeat (4) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("t1_busy", 128'(busy), 128'h0);
    checkOutput("t1_done", 128'(done), 128'h0);
    checkOutput("t1_ct_count", 128'(ct_count), 128'h0);

    // 2: single encryption
    clearMon();
    applyStimulus(1'b1, 1'b1, 32'd1);
    waitDone(200);
    checkOutput("t2_seed_cycles", 128'(mon_seed), 128'd1);
    checkOutput("t2_aes_cycles", 128'(mon_aes), 128'd22);
    checkOutput("t2_valid_cycles", 128'(mon_valid), 128'd1);
    checkOutput("t2_valid_offset", 128'(mon_first_valid - mon_first_aes), 128'd21);
    checkOutput("t2_ct_count", 128'(ct_count), 128'd1);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);

    // 3: five encryptions, consecutive valids and signature
    clearMon();
    applyStimulus(1'b1, 1'b1, 32'd5);
    waitDone(200);
    checkOutput("t3_valid_cycles", 128'(mon_valid), 128'd5);
    checkOutput("t3_valid_span", 128'(mon_last_valid - mon_first_valid + 1), 128'd5);
    checkOutput("t3_valid_offset", 128'(mon_first_valid - mon_first_aes), 128'd21);
    checkOutput("t3_ct_count", 128'(ct_count), 128'd5);
    applyStimulus(1'b1, 1'b0, '0);

    // 4: zero test count is ignored
    repeat (5) applyStimulus(1'b1, 1'b1, '0);
    checkOutput("t4_busy", 128'(busy), 128'h0);
    checkOutput("t4_done", 128'(done), 128'h0);
    applyStimulus(1'b1, 1'b0, '0);

    // 5: reset in the third drain cycle, then a clean rerun
    applyStimulus(1'b1, 1'b1, 32'd10);
    for (int i = 0; i < 100 && !(m_active && m_k == 10 + 4); i++) applyStimulus(1'b1, 1'b0, 32'd10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_busy", 128'(busy), 128'h0);
    checkOutput("t5_aes_enable", 128'(aes_enable), 128'h0);
    checkOutput("t5_lfsr_enable", 128'(lfsr_enable), 128'h0);
    checkOutput("t5_ct_valid", 128'(ct_valid), 128'h0);
    checkOutput("t5_ct_count", 128'(ct_count), 128'h0);
    applyStimulus(1'b1, 1'b1, 32'd2);
    waitDone(200);
    checkOutput("t5_rerun_count", 128'(ct_count), 128'd2);
    applyStimulus(1'b1, 1'b0, '0);

    // 6: start toggles mid-run are ignored; done holds while start stays high
    applyStimulus(1'b1, 1'b1, 32'd30);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 32'($urandom));
    applyStimulus(1'b1, 1'b1, 32'd7);
    waitDone(200);
    checkOutput("t6_ct_count", 128'(ct_count), 128'd30);
    dcnt = done ? 1 : 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_done_hold", 128'(dcnt), 128'd4);
    checkOutput("t6_done_released", 128'(done), 128'h0);
    checkOutput("t6_busy_idle", 128'(busy), 128'h0);

    // Randomised runs with random hold time in DONE
    for (int r = 0; r < 6; r++) begin
      n = 32'($urandom_range(1, 40));
      applyStimulus(1'b1, 1'b1, n);
      waitDone(200);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b1, 1'b1, n);
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
